// File: rtl/div8by4_seq_if.sv
// Handshake bundle for the sequential divider: operand request channel
// (in_valid/in_ready) and result channel (out_valid/out_ready).
interface div8by4_seq_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;

  // Requester side: supplies operands, consumes results.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_zero
  );

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_zero
  );
endinterface

// File: rtl/div8by4_seq.sv
// Sequential restoring divider: DW-bit unsigned dividend / VW-bit unsigned
// divisor, one quotient bit per clock. Divide-by-zero completes immediately
// with an all-ones quotient and the dividend's low bits as remainder.
module div8by4_seq #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input logic             clk,
  input logic             rst_n,
  div8by4_seq_if.slave    bus
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] dvd_sh;       // dividend bits still to consume; quotient bits shift in at the bottom
  logic [VW:0]   prem;         // partial remainder, one bit wider than the divisor
  logic [VW-1:0] dsr;          // latched divisor
  logic [CW-1:0] cnt;          // iteration index 0..DW-1
  logic [DW-1:0] quotient_q;
  logic [VW-1:0] remainder_q;
  logic          div_zero_q;

  logic          q_bit;
  logic [VW:0]   next_rem;

  // One restoring step. The shifted value can never exceed 2*divisor-1, so
  // its top bit is always zero and the VW+1-bit difference cannot wrap when
  // the subtract is taken. Returns {quotient_bit, new_partial_remainder}.
  function automatic logic [VW+1:0] restore_step(
    input logic [VW:0]   rem_in,
    input logic          bit_in,
    input logic [VW-1:0] dsr_in
  );
    logic [VW+1:0] shifted;
    logic [VW:0]   diff;
    logic          ge;
    shifted = {rem_in, bit_in};
    ge      = (shifted >= {2'b00, dsr_in});
    diff    = shifted[VW:0] - {1'b0, dsr_in};
    return ge ? {1'b1, diff} : {1'b0, shifted[VW:0]};
  endfunction

  // Datapath for the current iteration, consumed by the FSM below.
  always_comb begin
    {q_bit, next_rem} = restore_step(prem, dvd_sh[DW-1], dsr);
  end

  // Control FSM plus operand/working/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd_sh      <= '0;
      prem        <= '0;
      dsr         <= '0;
      cnt         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= bus.dividend[VW-1:0];
              div_zero_q  <= 1'b1;
              state       <= DONE;
            end else begin
              dvd_sh <= bus.dividend;
              dsr    <= bus.divisor;
              prem   <= '0;
              cnt    <= '0;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          dvd_sh <= {dvd_sh[DW-2:0], q_bit};
          prem   <= next_rem;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(DW - 1)) begin
            quotient_q  <= {dvd_sh[DW-2:0], q_bit};
            remainder_q <= next_rem[VW-1:0];
            div_zero_q  <= 1'b0;
            cnt         <= '0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;

endmodule
